// File: rtl/ifetch_queue.sv
// Instruction fetch front end: fetch PC, single-outstanding imem req/ack,
// and a small FIFO feeding the decode stage with instruction word and PC+4.
`timescale 1ns/1ps
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     stallD,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     validD,
  output logic [31:0]              instrD,
  output logic [5:0]               opD,
  output logic [5:0]               fnD,
  output logic [31:0]              pcplus4D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_reg, state_next;
  logic            req_reg, req_next;
  logic [31:0]     addr_reg, addr_next;
  logic [31:0]     fpc_reg, fpc_next;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [CW-1:0]   count_pop;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc4_mem   [DEPTH];
  logic            pop, ack, push, flush, do_pop;
  logic [31:0]     addr_plus4;

  assign pop        = (count_reg != '0) && !stallD;
  assign ack        = req_reg && imem_ack;
  assign addr_plus4 = addr_reg + 32'd4;
  assign count_pop  = count_reg - CW'(pop);

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    fpc_next   = fpc_reg;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fpc_next   = redirect_pc;
          state_next = WAIT;
          req_next   = 1'b1;
          addr_next  = redirect_pc;
        end else if (count_pop < CW'(DEPTH)) begin
          state_next = WAIT;
          req_next   = 1'b1;
          addr_next  = fpc_reg;
        end
      end
      WAIT: begin
        if (redirect) begin
          flush    = 1'b1;
          fpc_next = redirect_pc;
          // An outstanding request cannot be cancelled, so its data must be dropped.
          if (ack) addr_next = redirect_pc;
          else     state_next = DROP;
        end else if (ack) begin
          push      = 1'b1;
          fpc_next  = addr_plus4;
          addr_next = addr_plus4;
          if (count_pop + CW'(1) >= CW'(DEPTH)) begin
            state_next = IDLE;
            req_next   = 1'b0;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          flush    = 1'b1;
          fpc_next = redirect_pc;
          if (ack) begin
            state_next = WAIT;
            addr_next  = redirect_pc;
          end
        end else if (ack) begin
          state_next = WAIT;
          addr_next  = fpc_reg;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  assign do_pop     = pop && !flush;
  assign count_next = flush ? '0 : (count_reg + CW'(push) - CW'(do_pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      req_reg    <= 1'b0;
      addr_reg   <= RESET_PC;
      fpc_reg    <= RESET_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      fpc_reg   <= fpc_next;
      count_reg <= count_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push)   wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (do_pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  // Storage is cleared on reset so the head fields read zero until filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc4_mem[i]   <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc4_mem[wr_ptr_reg]   <= addr_plus4;
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign validD    = (count_reg != '0);
  assign instrD    = instr_mem[rd_ptr_reg];
  assign pcplus4D  = pc4_mem[rd_ptr_reg];
  assign opD       = instrD[31:26];
  assign fnD       = instrD[5:0];
  assign count     = count_reg;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        stallD = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        validD;
  logic [31:0] instrD;
  logic [5:0]  opD, fnD;
  logic [31:0] pcplus4D;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_fail = 0;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stallD(stallD),
    .redirect(redirect), .redirect_pc(redirect_pc), .validD(validD),
    .instrD(instrD), .opD(opD), .fnD(fnD), .pcplus4D(pcplus4D), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch request flags plus a plain queue of entries.
  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];
  bit          m_req, m_drop;
  logic [31:0] m_addr, m_fpc;

  task automatic model_step();
    bit pop;
    if (!rst) begin
      mq_i.delete(); mq_p.delete();
      m_req = 0; m_drop = 0; m_addr = 32'h0; m_fpc = 32'h0;
      return;
    end
    pop = (mq_i.size() != 0) && !stallD;
    if (redirect) begin
      mq_i.delete(); mq_p.delete();
      m_fpc = redirect_pc;
      if (m_req && !imem_ack) m_drop = 1;
      else begin m_req = 1; m_drop = 0; m_addr = redirect_pc; end
    end else if (m_req && imem_ack && m_drop) begin
      m_drop = 0;
      m_addr = m_fpc;
    end else if (m_req && imem_ack) begin
      mq_i.push_back(mem_word(m_addr));
      mq_p.push_back(m_addr + 32'd4);
      if (pop) begin void'(mq_i.pop_front()); void'(mq_p.pop_front()); end
      m_fpc  = m_addr + 32'd4;
      m_addr = m_fpc;
      m_req  = (mq_i.size() < DEPTH);
    end else begin
      if (pop) begin void'(mq_i.pop_front()); void'(mq_p.pop_front()); end
      if (!m_req && mq_i.size() < DEPTH) begin m_req = 1; m_addr = m_fpc; end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #2;
    chk("m_count", 32'(count), 32'(mq_i.size()));
    chk("m_validD", 32'(validD), 32'(mq_i.size() != 0));
    chk("m_req", 32'(imem_req), 32'(m_req));
    chk("m_addr", imem_addr, m_addr);
    if (mq_i.size() != 0) begin
      chk("m_instrD", instrD, mq_i[0]);
      chk("m_pcplus4D", pcplus4D, mq_p[0]);
      chk("m_opD", 32'(opD), 32'(mq_i[0][31:26]));
      chk("m_fnD", 32'(fnD), 32'(mq_i[0][5:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; stallD = 1'b0; imem_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_validD", 32'(validD), 32'h0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);
    tick();

    // Stream at one word per cycle
    rst = 1'b1; imem_ack = 1'b1; stallD = 1'b0;
    tick();
    chk("str_req1", 32'(imem_req), 32'h1);
    chk("str_addr1", imem_addr, 32'h0);
    chk("str_valid1", 32'(validD), 32'h0);
    tick();
    chk("str_valid2", 32'(validD), 32'h1);
    chk("str_instr2", instrD, 32'hA000_0000);
    chk("str_pc4_2", pcplus4D, 32'h4);
    chk("str_addr2", imem_addr, 32'h4);
    tick();
    chk("str_pc4_3", pcplus4D, 32'h8);
    chk("str_cnt3", 32'(count), 32'h1);
    for (int i = 0; i < 8; i++) tick();

    // Fill under stall
    do_reset();
    stallD = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_req", 32'(imem_req), 32'h0);
    chk("fill_addr", imem_addr, 32'h10);
    chk("fill_head", pcplus4D, 32'h4);
    stallD = 1'b0;
    tick();
    chk("rel_count", 32'(count), 32'h3);
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h10);
    chk("rel_head", pcplus4D, 32'h8);
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stallD = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Slow memory with intermittent stalls
    do_reset();
    for (int i = 0; i < 48; i++) begin
      imem_ack = (i % 3 == 2);
      stallD   = (i % 5 == 4) || (i >= 20 && i < 34);
      tick();
    end

    // Redirect on the same edge as an ack with two entries queued
    do_reset();
    stallD = 1'b1; imem_ack = 1'b1;
    tick(); tick(); tick();
    chk("rda_count", 32'(count), 32'h2);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("rda_count0", 32'(count), 32'h0);
    chk("rda_valid0", 32'(validD), 32'h0);
    chk("rda_req", 32'(imem_req), 32'h1);
    chk("rda_addr", imem_addr, 32'h40);
    redirect = 1'b0; stallD = 1'b0;
    tick();
    chk("rda_valid", 32'(validD), 32'h1);
    chk("rda_pc4", pcplus4D, 32'h44);
    chk("rda_instr", instrD, 32'hA000_0040);
    tick(); tick();

    // Redirect mid-transaction, then a second redirect while dropping
    do_reset();
    imem_ack = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("drp_req", 32'(imem_req), 32'h1);
    chk("drp_addr", imem_addr, 32'h0);
    redirect_pc = 32'hC0;
    tick();
    chk("drp_addr2", imem_addr, 32'h0);
    redirect = 1'b0; imem_ack = 1'b1;
    tick();
    chk("drp_new_addr", imem_addr, 32'hC0);
    chk("drp_valid", 32'(validD), 32'h0);
    tick();
    chk("drp_pc4", pcplus4D, 32'hC4);
    chk("drp_instr", instrD, 32'hA000_00C0);
    tick(); tick();

    // Asynchronous reset mid-cycle
    do_reset();
    stallD = 1'b1; imem_ack = 1'b1;
    tick(); tick(); tick(); tick();
    chk("ar_count3", 32'(count), 32'h3);
    chk("ar_addr12", imem_addr, 32'hC);
    #1 rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'h0);
    chk("ar_valid", 32'(validD), 32'h0);
    chk("ar_req", 32'(imem_req), 32'h0);
    chk("ar_instr", instrD, 32'h0);
    chk("ar_pc4", pcplus4D, 32'h0);
    tick(); tick();
    rst = 1'b1; stallD = 1'b0;
    tick();
    chk("ar_restart_req", 32'(imem_req), 32'h1);
    chk("ar_restart_addr", imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
